id_instr_assembler: RTL and testbench
=====================================

# id_instr_assembler

Decode-side receiver for the fetch stage's 16-bit instruction stream, sitting between fetch and the IF/ID pipeline register. Pairs each immediate-class opcode word with the 16-bit immediate word that follows it, emits one complete instruction per slot, and presents a NOP bubble while an immediate is outstanding or after a flush. Honours hazard stall and jump flush so decode only ever sees whole instructions.

## Interface

Parameters
- `PC_W`, 32, program-counter width (word-addressed)
- `NOP_WORD`, 16'h0000, instruction word driven on bubbles

Ports
- `clk` in 1: rising-edge clock
- `rst` in 1: synchronous, active-high reset
- `in_valid` in 1: fetch word present this cycle
- `in_word` in 16: fetched word (opcode or immediate)
- `in_pc` in PC_W: word address of `in_word`
- `stall` in 1: hazard stall; hold all state and outputs, consume nothing
- `flush` in 1: taken jump/branch or interrupt redirect; discard everything in flight
- `out_valid` out 1: `out_instr` is a real, complete instruction
- `out_instr` out 16: opcode word to decode
- `out_imm` out 16: immediate word; 0 when `out_has_imm`=0
- `out_has_imm` out 1: instruction carried an immediate
- `out_pc` out PC_W: address of the opcode word
- `out_next_pc` out PC_W: `out_pc` + 1 or + 2 (if `out_has_imm`), mod 2^PC_W
- `iam_bubble` out 1: equals ~`out_valid`

## Operation

- FSM states: `S_OPC` (expect opcode), `S_IMM` (opcode latched in holding register, expect immediate).
- Immediate-class test: `needs_imm(w)` = `w[15:14]==2'b10`; defined only in the package.
- Priority per cycle: `rst` > `flush` > `stall` > `in_valid`.
- `rst`: state `S_OPC`; holding register cleared; `out_valid`=0, `out_instr`=NOP_WORD, `out_imm`=0, `out_has_imm`=0, `out_pc`=0, `out_next_pc`=0, `iam_bubble`=1.
- `flush`: same register values as reset; any half-assembled opcode dropped; word on `in_word` this cycle ignored.
- `stall`: state, holding register and all outputs unchanged; `in_word` not consumed (fetch holds it).
- `S_OPC`, `in_valid`=1, !`needs_imm`: output register loads instruction, `out_has_imm`=0, `out_valid`=1; stay `S_OPC`.
- `S_OPC`, `in_valid`=1, `needs_imm`: latch word + `in_pc` into holding register; output register loads bubble; go `S_IMM`.
- `S_IMM`, `in_valid`=1: output loads held opcode, `out_imm`=`in_word`, `out_has_imm`=1, `out_pc`=held PC; go `S_OPC`. Word is never re-tested with `needs_imm`.
- `S_IMM` or `S_OPC`, `in_valid`=0: output loads bubble; state and holding register kept.
- `out_next_pc` computed from the value loaded into `out_pc`; carry out discarded.

## Timing

- All outputs registered; no combinational path from inputs to outputs.
- Non-immediate instruction accepted at edge N: visible at N+1.
- Immediate instruction: opcode at edge N, immediate at N+1; bubble visible after N+1's opcode edge, full instruction visible after the immediate edge (one bubble per immediate instruction).
- Stall of k cycles: outputs frozen k cycles; no bubble inserted by this block.
- Flush in the same cycle as the immediate word: pair discarded, bubble next cycle.
- Back-to-back immediate instructions: sustained throughput of one instruction per two cycles, alternating bubble/valid.

## Structure

- Shared package `isa_pkg`: `needs_imm` function, `NOP_WORD`, opcode field positions, FSM state enum `asm_state_t`.
- Single module; no sub-module. Holding register and output register are plain registers in the same file.

## Test plan

- Reset mid-`S_IMM` (opcode 16'h8123 held) -> next cycle `out_valid`=0, `out_instr`=16'h0000, state `S_OPC`; following word 16'h1234 treated as opcode.
- Non-imm 16'h1234 @ pc 0x20 -> next cycle `out_valid`=1, `out_instr`=16'h1234, `out_has_imm`=0, `out_next_pc`=0x21.
- Imm pair 16'h8005 @0x30 then 16'hBEEF -> bubble, then `out_instr`=16'h8005, `out_imm`=16'hBEEF, `out_pc`=0x30, `out_next_pc`=0x32.
- `stall` for 3 cycles in `S_IMM` with immediate on input -> outputs frozen 3 cycles, pair completes on first unstalled edge.
- `flush` and `stall` both high while in `S_IMM` -> flush wins: bubble, `S_OPC`, opcode lost.
- `in_pc`=0xFFFFFFFF, imm-class opcode, immediate at address 0 -> `out_next_pc`=0x00000001 (wrap).

Source files
------------

// File: rtl/isa_pkg.sv
// Instruction-set constants shared by the fetch/decode boundary logic.
package isa_pkg;

   localparam logic [15:0] NOP_WORD    = 16'h0000;
   localparam int          CLASS_HI    = 15;
   localparam int          CLASS_LO    = 14;
   localparam logic [1:0]  CLASS_IMM   = 2'b10;

   typedef enum logic {
      S_OPC = 1'b0,
      S_IMM = 1'b1
   } asm_state_t;

   function automatic logic needs_imm(input logic [15:0] w);
      return w[CLASS_HI:CLASS_LO] == CLASS_IMM;
   endfunction

endpackage

// File: rtl/id_instr_assembler.sv
// Pairs immediate-class opcode words with their trailing immediate word and
// presents whole instructions (or NOP bubbles) to the IF/ID register.
module id_instr_assembler #(
   parameter int          PC_W     = 32,
   parameter logic [15:0] NOP_WORD = isa_pkg::NOP_WORD
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [15:0]     in_word,
   input  logic [PC_W-1:0] in_pc,
   input  logic            stall,
   input  logic            flush,
   output logic            out_valid,
   output logic [15:0]     out_instr,
   output logic [15:0]     out_imm,
   output logic            out_has_imm,
   output logic [PC_W-1:0] out_pc,
   output logic [PC_W-1:0] out_next_pc,
   output logic            iam_bubble
);
   import isa_pkg::*;

   asm_state_t      state_q, state_d;
   logic [15:0]     hold_word_q, hold_word_d;
   logic [PC_W-1:0] hold_pc_q, hold_pc_d;

   logic            out_valid_q, out_valid_d;
   logic [15:0]     out_instr_q, out_instr_d;
   logic [15:0]     out_imm_q, out_imm_d;
   logic            out_has_imm_q, out_has_imm_d;
   logic [PC_W-1:0] out_pc_q, out_pc_d;
   logic [PC_W-1:0] out_next_pc_q, out_next_pc_d;

   always_comb begin
      state_d       = state_q;
      hold_word_d   = hold_word_q;
      hold_pc_d     = hold_pc_q;
      out_valid_d   = out_valid_q;
      out_instr_d   = out_instr_q;
      out_imm_d     = out_imm_q;
      out_has_imm_d = out_has_imm_q;
      out_pc_d      = out_pc_q;
      out_next_pc_d = out_next_pc_q;

      if (flush) begin
         state_d       = S_OPC;
         hold_word_d   = '0;
         hold_pc_d     = '0;
         out_valid_d   = 1'b0;
         out_instr_d   = NOP_WORD;
         out_imm_d     = '0;
         out_has_imm_d = 1'b0;
         out_pc_d      = '0;
         out_next_pc_d = '0;
      end else if (!stall) begin
         // Bubble by default; overwritten below when a whole instruction forms.
         out_valid_d   = 1'b0;
         out_instr_d   = NOP_WORD;
         out_imm_d     = '0;
         out_has_imm_d = 1'b0;
         out_pc_d      = '0;
         out_next_pc_d = '0;
         if (in_valid) begin
            unique case (state_q)
               S_OPC: begin
                  if (needs_imm(in_word)) begin
                     hold_word_d = in_word;
                     hold_pc_d   = in_pc;
                     state_d     = S_IMM;
                  end else begin
                     out_valid_d   = 1'b1;
                     out_instr_d   = in_word;
                     out_pc_d      = in_pc;
                     out_next_pc_d = in_pc + PC_W'(1);
                  end
               end
               S_IMM: begin
                  // The word here is always data, never re-classified.
                  out_valid_d   = 1'b1;
                  out_instr_d   = hold_word_q;
                  out_imm_d     = in_word;
                  out_has_imm_d = 1'b1;
                  out_pc_d      = hold_pc_q;
                  out_next_pc_d = hold_pc_q + PC_W'(2);
                  state_d       = S_OPC;
               end
               default: state_d = S_OPC;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_OPC;
         hold_word_q   <= '0;
         hold_pc_q     <= '0;
         out_valid_q   <= 1'b0;
         out_instr_q   <= NOP_WORD;
         out_imm_q     <= '0;
         out_has_imm_q <= 1'b0;
         out_pc_q      <= '0;
         out_next_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         hold_word_q   <= hold_word_d;
         hold_pc_q     <= hold_pc_d;
         out_valid_q   <= out_valid_d;
         out_instr_q   <= out_instr_d;
         out_imm_q     <= out_imm_d;
         out_has_imm_q <= out_has_imm_d;
         out_pc_q      <= out_pc_d;
         out_next_pc_q <= out_next_pc_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_instr   = out_instr_q;
   assign out_imm     = out_imm_q;
   assign out_has_imm = out_has_imm_q;
   assign out_pc      = out_pc_q;
   assign out_next_pc = out_next_pc_q;
   assign iam_bubble  = ~out_valid_q;

endmodule

// File: tb/tb_id_instr_assembler.sv
// Directed bench for id_instr_assembler: one task per scenario, inline checks.
module tb_id_instr_assembler;

   localparam int PC_W = 32;
   localparam int SW   = 1 + 16 + 16 + 1 + PC_W + PC_W + 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic [15:0]     in_word;
   logic [PC_W-1:0] in_pc;
   logic            stall;
   logic            flush;
   logic            out_valid;
   logic [15:0]     out_instr;
   logic [15:0]     out_imm;
   logic            out_has_imm;
   logic [PC_W-1:0] out_pc;
   logic [PC_W-1:0] out_next_pc;
   logic            iam_bubble;

   int n_cmp = 0;
   int n_bad = 0;
   logic [SW-1:0] obs, exp_v;

   id_instr_assembler #(.PC_W(PC_W), .NOP_WORD(16'h0000)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word),
      .in_pc(in_pc), .stall(stall), .flush(flush),
      .out_valid(out_valid), .out_instr(out_instr), .out_imm(out_imm),
      .out_has_imm(out_has_imm), .out_pc(out_pc), .out_next_pc(out_next_pc),
      .iam_bubble(iam_bubble)
   );

   always #5 clk = ~clk;

   function automatic logic [SW-1:0] snap();
      return {out_valid, out_instr, out_imm, out_has_imm, out_pc, out_next_pc, iam_bubble};
   endfunction

   // Expected snapshot; iam_bubble is written explicitly as the inverse of v.
   function automatic logic [SW-1:0] mk(input logic v, input logic [15:0] ins,
                                        input logic [15:0] imm, input logic has,
                                        input logic [PC_W-1:0] pc,
                                        input logic [PC_W-1:0] npc, input logic bub);
      return {v, ins, imm, has, pc, npc, bub};
   endfunction

   localparam logic [SW-1:0] BUBBLE = {1'b0, 16'h0000, 16'h0000, 1'b0, 32'h0, 32'h0, 1'b1};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] w, input logic [PC_W-1:0] pc);
      in_valid = v;
      in_word  = w;
      in_pc    = pc;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      drive(1'b0, 16'h0, 32'h0);
      step(); step();
      obs = snap();
      n_cmp++;
      if (obs !== BUBBLE) begin
         n_bad++; $display("FAIL reset_init: got %h want %h", obs, BUBBLE);
      end
      rst = 1'b0;
      drive(1'b1, 16'h8123, 32'h10);
      step();
      obs = snap();
      n_cmp++;
      if (obs !== BUBBLE) begin
         n_bad++; $display("FAIL reset_opc_bubble: got %h want %h", obs, BUBBLE);
      end
      rst = 1'b1;
      drive(1'b0, 16'h0, 32'h0);
      step();
      obs = snap();
      n_cmp++;
      if (obs !== BUBBLE) begin
         n_bad++; $display("FAIL reset_mid_imm: got %h want %h", obs, BUBBLE);
      end
      rst = 1'b0;
      drive(1'b1, 16'h1234, 32'h11);
      step();
      obs = snap();
      exp_v = mk(1'b1, 16'h1234, 16'h0, 1'b0, 32'h11, 32'h12, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++; $display("FAIL reset_then_opcode: got %h want %h", obs, exp_v);
      end
   endtask

   task automatic test_nonimm();
      drive(1'b1, 16'h1234, 32'h20);
      step();
      obs = snap();
      exp_v = mk(1'b1, 16'h1234, 16'h0, 1'b0, 32'h20, 32'h21, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++; $display("FAIL nonimm: got %h want %h", obs, exp_v);
      end
      drive(1'b0, 16'h5555, 32'h21);
      step();
      obs = snap();
      n_cmp++;
      if (obs !== BUBBLE) begin
         n_bad++; $display("FAIL idle_bubble: got %h want %h", obs, BUBBLE);
      end
   endtask

   task automatic test_imm_pair();
      drive(1'b1, 16'h8005, 32'h30);
      step();
      obs = snap();
      n_cmp++;
      if (obs !== BUBBLE) begin
         n_bad++; $display("FAIL imm_pair_bubble: got %h want %h", obs, BUBBLE);
      end
      drive(1'b1, 16'hBEEF, 32'h31);
      step();
      obs = snap();
      exp_v = mk(1'b1, 16'h8005, 16'hBEEF, 1'b1, 32'h30, 32'h32, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++; $display("FAIL imm_pair_full: got %h want %h", obs, exp_v);
      end
   endtask

   task automatic test_stall();
      drive(1'b1, 16'h0777, 32'h3E);
      step();
      exp_v = mk(1'b1, 16'h0777, 16'h0, 1'b0, 32'h3E, 32'h3F, 1'b0);
      stall = 1'b1;
      drive(1'b1, 16'h4444, 32'h3F);
      for (int i = 0; i < 2; i++) begin
         step();
         obs = snap();
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++; $display("FAIL stall_hold_valid[%0d]: got %h want %h", i, obs, exp_v);
         end
      end
      stall = 1'b0;
      drive(1'b1, 16'h8AAA, 32'h40);
      step();
      stall = 1'b1;
      drive(1'b1, 16'h9ABC, 32'h41);
      for (int i = 0; i < 3; i++) begin
         step();
         obs = snap();
         n_cmp++;
         if (obs !== BUBBLE) begin
            n_bad++; $display("FAIL stall_hold_imm[%0d]: got %h want %h", i, obs, BUBBLE);
         end
      end
      stall = 1'b0;
      step();
      obs = snap();
      exp_v = mk(1'b1, 16'h8AAA, 16'h9ABC, 1'b1, 32'h40, 32'h42, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++; $display("FAIL stall_release: got %h want %h", obs, exp_v);
      end
   endtask

   task automatic test_flush();
      drive(1'b1, 16'h8123, 32'h50);
      step();
      flush = 1'b1; stall = 1'b1;
      drive(1'b1, 16'hBEEF, 32'h51);
      step();
      obs = snap();
      n_cmp++;
      if (obs !== BUBBLE) begin
         n_bad++; $display("FAIL flush_over_stall: got %h want %h", obs, BUBBLE);
      end
      flush = 1'b0; stall = 1'b0;
      drive(1'b1, 16'h2222, 32'h52);
      step();
      obs = snap();
      exp_v = mk(1'b1, 16'h2222, 16'h0, 1'b0, 32'h52, 32'h53, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++; $display("FAIL flush_opcode_lost: got %h want %h", obs, exp_v);
      end
      flush = 1'b1;
      drive(1'b1, 16'h3333, 32'h53);
      step();
      flush = 1'b0;
      obs = snap();
      n_cmp++;
      if (obs !== BUBBLE) begin
         n_bad++; $display("FAIL flush_clears_valid: got %h want %h", obs, BUBBLE);
      end
   endtask

   task automatic test_wrap();
      drive(1'b1, 16'h8001, 32'hFFFF_FFFF);
      step();
      drive(1'b1, 16'h0055, 32'h0);
      step();
      obs = snap();
      exp_v = mk(1'b1, 16'h8001, 16'h0055, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++; $display("FAIL pc_wrap: got %h want %h", obs, exp_v);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] opc [3];
      logic [15:0] imm [3];
      opc[0] = 16'h8001; opc[1] = 16'hBF02; opc[2] = 16'h8003;
      imm[0] = 16'h1111; imm[1] = 16'h8222; imm[2] = 16'hC333;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, opc[i], 32'h100 + 32'(2 * i));
         step();
         obs = snap();
         n_cmp++;
         if (obs !== BUBBLE) begin
            n_bad++; $display("FAIL b2b_bubble[%0d]: got %h want %h", i, obs, BUBBLE);
         end
         drive(1'b1, imm[i], 32'h101 + 32'(2 * i));
         step();
         obs = snap();
         exp_v = mk(1'b1, opc[i], imm[i], 1'b1, 32'h100 + 32'(2 * i),
                    32'h102 + 32'(2 * i), 1'b0);
         n_cmp++;
         if (obs !== exp_v) begin
            n_bad++; $display("FAIL b2b_full[%0d]: got %h want %h", i, obs, exp_v);
         end
      end
      drive(1'b0, 16'h0, 32'h0);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      in_valid = 1'b0; in_word = 16'h0; in_pc = '0;
      test_reset();
      test_nonimm();
      test_imm_pair();
      test_stall();
      test_flush();
      test_wrap();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
